fetch_unit: RTL



---
 rtl/core101_pkg.sv | 18 +
 rtl/fetch_watchdog.sv | 33 +++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/core101_pkg.sv
// Shared definitions for the Core101 front end.
//   DEFAULT_XLEN         : default datapath / address width
//   DEFAULT_RESET_VECTOR : default first fetch address after reset
//   fetch_state_e        : instruction-fetch FSM state encoding
//   INSN_BYTES           : size of one instruction word in bytes
package core101_pkg;

  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          INSN_BYTES           = 4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating wait counter for the instruction-memory request.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   waiting  : a request is outstanding and memory is not ready this cycle
//   timeout  : one-cycle pulse when this waiting cycle is the TIMEOUT-th in a row
module fetch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // Any cycle that is not a waiting cycle (accept, redirect, no request)
  // restarts the count, so only consecutive stalls are measured.
  always_ff @(posedge clk) begin
    if (rst || !waiting) begin
      count_q <= '0;
    end else if (count_q != CW'(TIMEOUT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Fires in the cycle whose wait brings the count to TIMEOUT, so the
  // owner can change state on the same edge the count gets there.
  assign timeout = waiting && (count_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Core101 instruction-fetch front end.
// Owns the PC, requests words from instruction memory and keeps a one-entry
// buffer toward decode. Supports redirect with flush and a sticky timeout.
// Ports:
//   clock_in, reset_in          : clock, synchronous active-high reset
//   ins_mem_valid_out/addr_out  : fetch request and word-aligned address
//   ins_mem_ready_in/data_in    : memory accepts and returns data same cycle
//   redirect_valid_in/addr_in   : new PC (branch/jump/trap), low bits ignored
//   dec_valid_out/ins_out/pc_out: buffered instruction toward decode
//   dec_ready_in                : decode consumes the buffer this cycle
//   fetch_err_out               : sticky memory-timeout error
//   dbg_state                   : current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The sender holds valid and its payload stable until that edge,
// except that a redirect may withdraw a fetch request.
module fetch_unit
  import core101_pkg::*;
#(
  parameter int             XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int             TIMEOUT      = 64
) (
  input  logic             clock_in,
  input  logic             reset_in,
  output logic             ins_mem_valid_out,
  output logic [XLEN-1:0]  ins_mem_addr_out,
  input  logic             ins_mem_ready_in,
  input  logic [31:0]      ins_mem_data_in,
  input  logic             redirect_valid_in,
  input  logic [XLEN-1:0]  redirect_addr_in,
  output logic             dec_valid_out,
  output logic [31:0]      dec_ins_out,
  output logic [XLEN-1:0]  dec_pc_out,
  input  logic             dec_ready_in,
  output logic             fetch_err_out,
  output fetch_state_e     dbg_state
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_target;
  logic            accept;
  logic            waiting;
  logic            timeout;

  assign redirect_target = redirect_addr_in & ~XLEN'(INSN_BYTES - 1);
  assign accept          = ins_mem_valid_out && ins_mem_ready_in;
  assign waiting         = ins_mem_valid_out && !ins_mem_ready_in;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clock_in),
    .rst     (reset_in),
    .waiting (waiting),
    .timeout (timeout)
  );

  // FSM state register
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (timeout) state_d = S_ERR;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM outputs. A request needs room in the buffer: either it is empty or
  // decode is draining it this cycle, which gives 1 instruction/cycle.
  always_comb begin
    ins_mem_valid_out = (state_q == S_RUN) && !redirect_valid_in &&
                        (!dec_valid_out || dec_ready_in);
    fetch_err_out     = (state_q == S_ERR);
  end

  assign ins_mem_addr_out = pc_q;
  assign dbg_state        = state_q;

  // PC and decode buffer. Redirect wins over everything except reset; it
  // only flushes the buffer while running so an error state can still drain.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      pc_q          <= RESET_VECTOR;
      dec_valid_out <= 1'b0;
      dec_ins_out   <= '0;
      dec_pc_out    <= '0;
    end else if (redirect_valid_in) begin
      pc_q <= redirect_target;
      if (state_q == S_RUN) begin
        dec_valid_out <= 1'b0;
      end else if (dec_valid_out && dec_ready_in) begin
        dec_valid_out <= 1'b0;
      end
    end else if (accept) begin
      dec_ins_out   <= ins_mem_data_in;
      dec_pc_out    <= pc_q;
      dec_valid_out <= 1'b1;
      pc_q          <= pc_q + XLEN'(INSN_BYTES);
    end else if (dec_valid_out && dec_ready_in) begin
      dec_valid_out <= 1'b0;
    end
  end

endmodule
